stage0_prefetch: RTL and testbench

Parametrised instruction-fetch stage with a prefetch FIFO. It generates fetch addresses, reads instruction words from either the boot ROM (combinational, one word per cycle) or RAM (req/ack handshake, variable latency), buffers them, and presents them to stage 1 with a valid/ready handshake. Redirects (jumps, boot-to-RAM switch) flush the buffer and restart fetch at a new PC and source.

---
 rtl/stage0_prefetch.sv | 209 ++++++++++++++++++++
 tb/tb_stage0_prefetch.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stage0_prefetch.sv
// Instruction-fetch stage: fetches words from boot ROM or RAM into a small
// prefetch FIFO and hands them to stage 1 over a valid/ready handshake.
// A redirect flushes the FIFO and restarts fetch at a new PC and source.
// If a RAM read is in flight when the redirect arrives, the stage waits in
// DRAIN for that read to complete and throws its data away.
module stage0_prefetch #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 16,
    parameter int                    DEPTH      = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    input  logic                  redirect_from_ram,
    output logic [ADDR_WIDTH-1:0] brom_address,
    input  logic [DATA_WIDTH-1:0] brom_value,
    output logic                  ram_req,
    output logic [ADDR_WIDTH-1:0] ram_address,
    input  logic                  ram_ack,
    input  logic [DATA_WIDTH-1:0] ram_value,
    output logic [DATA_WIDTH-1:0] instruction_binary,
    output logic [ADDR_WIDTH-1:0] instr_pc,
    output logic                  instr_valid,
    input  logic                  instr_ready,
    output logic                  execute_from_ram
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic {FETCH = 1'b0, DRAIN = 1'b1} state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   pc_q, pc_d;
    logic [ADDR_WIDTH-1:0]   drain_addr_q, drain_addr_d;
    logic                    from_ram_q, from_ram_d;
    logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]        count_q, count_d;
    logic [DATA_WIDTH-1:0]   head_data_q, head_data_d;
    logic [ADDR_WIDTH-1:0]   head_pc_q, head_pc_d;
    logic [DATA_WIDTH-1:0]   entry_data [DEPTH];
    logic [ADDR_WIDTH-1:0]   entry_pc [DEPTH];
    logic                    fifo_full;
    logic                    push;
    logic                    pop;
    logic                    req;
    logic [ADDR_WIDTH-1:0]   req_addr;
    logic [DATA_WIDTH-1:0]   push_data;

    // Full is judged on the count at the start of the cycle, so a pop in the
    // same cycle never makes room for a push.
    assign fifo_full = (count_q == CNT_W'(DEPTH));
    assign pop       = (count_q != '0) && instr_ready && !redirect_valid;

    // Fetch control: source selection, RAM request, PC advance, redirect/drain.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        from_ram_d   = from_ram_q;
        drain_addr_d = drain_addr_q;
        push         = 1'b0;
        push_data    = brom_value;
        req          = 1'b0;
        req_addr     = pc_q;
        case (state_q)
            FETCH: begin
                if (from_ram_q) begin
                    // Nothing else can fill the FIFO while a read is pending,
                    // so the request stays stable until its ack.
                    req = !fifo_full;
                    if (req && ram_ack) begin
                        push      = 1'b1;
                        push_data = ram_value;
                    end
                end else begin
                    push = !fifo_full;
                end
                if (redirect_valid) begin
                    push       = 1'b0;
                    pc_d       = redirect_pc;
                    from_ram_d = redirect_from_ram;
                    if (req && !ram_ack) begin
                        state_d      = DRAIN;
                        drain_addr_d = pc_q;
                    end
                end else if (push) begin
                    pc_d = pc_q + ADDR_WIDTH'(1);
                end
            end
            DRAIN: begin
                // Keep the abandoned read alive until the RAM answers it.
                req      = 1'b1;
                req_addr = drain_addr_q;
                if (ram_ack) begin
                    state_d = FETCH;
                end
                if (redirect_valid) begin
                    pc_d       = redirect_pc;
                    from_ram_d = redirect_from_ram;
                end
            end
            default: state_d = FETCH;
        endcase
    end

    // FIFO pointers and occupancy; a redirect empties the FIFO but leaves the
    // read pointer (and so the presented head) where it was.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (redirect_valid) begin
            wr_ptr_d = rd_ptr_q;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Next head word; bypasses the entry being written when it becomes the
    // head, and holds the last value while the FIFO is empty.
    always_comb begin
        head_data_d = head_data_q;
        head_pc_d   = head_pc_q;
        if (count_d != '0) begin
            if (push && (wr_ptr_q == rd_ptr_d)) begin
                head_data_d = push_data;
                head_pc_d   = pc_q;
            end else begin
                head_data_d = entry_data[rd_ptr_d];
                head_pc_d   = entry_pc[rd_ptr_d];
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            logic [DATA_WIDTH-1:0] data_q, data_d;
            logic [ADDR_WIDTH-1:0] epc_q, epc_d;

            // Capture the pushed word when this slot is the write target.
            always_comb begin
                data_d = data_q;
                epc_d  = epc_q;
                if (push && (wr_ptr_q == PTR_W'(gi))) begin
                    data_d = push_data;
                    epc_d  = pc_q;
                end
            end

            // Entry storage.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    data_q <= '0;
                    epc_q  <= '0;
                end else begin
                    data_q <= data_d;
                    epc_q  <= epc_d;
                end
            end

            assign entry_data[gi] = data_q;
            assign entry_pc[gi]   = epc_q;
        end
    endgenerate

    // State, PC, pointers and head registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= FETCH;
            pc_q         <= RESET_PC;
            drain_addr_q <= '0;
            from_ram_q   <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            head_data_q  <= '0;
            head_pc_q    <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            drain_addr_q <= drain_addr_d;
            from_ram_q   <= from_ram_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            head_data_q  <= head_data_d;
            head_pc_q    <= head_pc_d;
        end
    end

    assign brom_address       = pc_q;
    assign ram_req            = req;
    assign ram_address        = req_addr;
    assign instruction_binary = head_data_q;
    assign instr_pc           = head_pc_q;
    assign instr_valid        = (count_q != '0);
    assign execute_from_ram   = from_ram_q;

endmodule

// File: tb/tb_stage0_prefetch.sv
// Bench for stage0_prefetch: ROM/RAM memory models, a scoreboard of the
// expected instruction stream (restarted on every redirect/reset), a monitor
// that checks each accepted word, and directed timing checks.
module tb_stage0_prefetch;

    localparam int          DW    = 32;
    localparam int          AW    = 16;
    localparam int          DEPTH = 4;
    localparam logic [15:0] RPC   = 16'd4;

    logic          clk;
    logic          reset;
    logic          redirect_valid;
    logic [AW-1:0] redirect_pc;
    logic          redirect_from_ram;
    logic [AW-1:0] brom_address;
    logic [DW-1:0] brom_value;
    logic          ram_req;
    logic [AW-1:0] ram_address;
    logic          ram_ack;
    logic [DW-1:0] ram_value;
    logic [DW-1:0] instruction_binary;
    logic [AW-1:0] instr_pc;
    logic          instr_valid;
    logic          instr_ready;
    logic          execute_from_ram;

    stage0_prefetch #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .RESET_PC(RPC)
    ) dut (
        .clk(clk), .reset(reset),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .redirect_from_ram(redirect_from_ram),
        .brom_address(brom_address), .brom_value(brom_value),
        .ram_req(ram_req), .ram_address(ram_address),
        .ram_ack(ram_ack), .ram_value(ram_value),
        .instruction_binary(instruction_binary), .instr_pc(instr_pc),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .execute_from_ram(execute_from_ram)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] rom_word(input logic [15:0] a);
        if (a == 16'd4) return 32'hFCACD0A9;
        return {a ^ 16'hA5C3, ~a} + 32'h1357_9BDF;
    endfunction

    function automatic logic [31:0] ram_word(input logic [15:0] a);
        if (a == 16'h0010) return 32'hE5F84AB1;
        return {~a, a} ^ 32'h3C3C_0F0F;
    endfunction

    assign brom_value = rom_word(brom_address);

    int checks = 0;
    int fails  = 0;
    int n_pops = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            fails++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp_v, $time);
        end
    endtask

    // Reference model: after a restart the delivered stream is pc, pc+1, ...
    // (wrapping at 16 bits) with words taken from the selected source.
    typedef struct packed {
        logic [31:0] data;
        logic [15:0] pc;
    } item_t;
    item_t exp_q[$];

    task automatic restart_model(input logic [15:0] pc, input logic src);
        logic [15:0] a;
        exp_q.delete();
        for (int i = 0; i < 256; i++) begin
            a = pc + 16'(i);
            exp_q.push_back({src ? ram_word(a) : rom_word(a), a});
        end
    endtask

    // Monitor: every accepted word must be the next one the model predicts.
    always @(negedge clk) begin
        item_t e;
        if (!reset && instr_valid && instr_ready && !redirect_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL pop_unexpected: got pc %h data %h, expected no word", instr_pc, instruction_binary);
            end else begin
                e = exp_q.pop_front();
                check("pop_word", {instruction_binary, instr_pc}, {e.data, e.pc});
                n_pops++;
                $display("pop pc=%h data=%h", instr_pc, instruction_binary);
            end
        end
    end

    // RAM model: acks a request after lat cycles; checks the request stays
    // stable until acked; forgets any pending request across reset.
    int          forced_lat = -1;
    bit          pend = 1'b0;
    int          wcnt = 0;
    int          lat  = 0;
    logic [15:0] paddr = '0;
    initial begin
        ram_ack   = 1'b0;
        ram_value = '0;
        forever begin
            @(posedge clk);
            #1;
            ram_ack = 1'b0;
            if (reset) begin
                pend = 1'b0;
            end else begin
                if (pend) begin
                    check("ram_req_held", ram_req, 1'b1);
                    if (ram_req) check("ram_addr_stable", ram_address, paddr);
                end
                if (ram_req) begin
                    if (!pend) begin
                        pend  = 1'b1;
                        wcnt  = 0;
                        paddr = ram_address;
                        lat   = (forced_lat >= 0) ? forced_lat : int'($urandom_range(0, 3));
                    end
                    if (wcnt == lat) begin
                        ram_ack   = 1'b1;
                        ram_value = ram_word(ram_address);
                        pend      = 1'b0;
                    end else begin
                        wcnt++;
                    end
                end else begin
                    pend = 1'b0;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue a one-cycle redirect; returns just after the edge that takes it.
    task automatic redirect(input logic [15:0] pc, input logic src);
        redirect_valid    = 1'b1;
        redirect_pc       = pc;
        redirect_from_ram = src;
        restart_model(pc, src);
        tick();
        redirect_valid = 1'b0;
        $display("redirect pc=%h from_ram=%0d", pc, src);
    endtask

    task automatic wait_valid(input string name, input int budget);
        int n;
        n = 0;
        while (!instr_valid && n < budget) begin
            tick();
            n++;
        end
        check(name, instr_valid, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        reset             = 1'b1;
        redirect_valid    = 1'b0;
        redirect_pc       = '0;
        redirect_from_ram = 1'b0;
        instr_ready       = 1'b0;
        #2;
        check("rst_valid", instr_valid, 1'b0);
        check("rst_ram_req", ram_req, 1'b0);
        check("rst_binary", instruction_binary, 32'h0);
        check("rst_pc", instr_pc, 16'h0);
        check("rst_brom_addr", brom_address, RPC);
        check("rst_from_ram", execute_from_ram, 1'b0);

        // Reset release, ROM fetch with stage 1 stalled.
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        restart_model(RPC, 1'b0);
        tick();
        check("first_valid", instr_valid, 1'b1);
        check("first_binary", instruction_binary, 32'hFCACD0A9);
        check("first_pc", instr_pc, 16'd4);
        repeat (9) tick();
        check("stall_brom_addr", brom_address, 16'd8);
        check("stall_head_pc", instr_pc, 16'd4);
        instr_ready = 1'b1;
        tick();
        check("no_bypass_brom", brom_address, 16'd8);
        check("drain1_pc", instr_pc, 16'd5);
        tick();
        check("resume_brom", brom_address, 16'd9);
        for (int i = 0; i < 6; i++) begin
            tick();
            check("rom_no_gap", instr_valid, 1'b1);
        end

        // Redirect to RAM with a fixed 2-cycle ack.
        forced_lat = 2;
        redirect(16'h0010, 1'b1);
        check("rd_ram_valid_low", instr_valid, 1'b0);
        check("rd_ram_req", ram_req, 1'b1);
        check("rd_ram_addr", ram_address, 16'h0010);
        check("rd_ram_src", execute_from_ram, 1'b1);
        wait_valid("ram_first_valid", 20);
        check("ram_first_binary", instruction_binary, 32'hE5F84AB1);
        check("ram_first_pc", instr_pc, 16'h0010);
        forced_lat = -1;
        for (int i = 0; i < 40; i++) begin
            tick();
            instr_ready = 1'($urandom_range(0, 1));
        end
        instr_ready = 1'b1;

        // Settle in ROM, then redirect away while a RAM read is pending.
        redirect(16'h0100, 1'b0);
        repeat (8) tick();
        forced_lat = 3;
        redirect(16'h0020, 1'b1);
        check("pend_req", ram_req, 1'b1);
        redirect(16'h0000, 1'b0);
        check("drain_req", ram_req, 1'b1);
        check("drain_addr", ram_address, 16'h0020);
        check("drain_valid_low", instr_valid, 1'b0);
        n = 0;
        #1;
        while (!ram_ack && n < 10) begin
            @(posedge clk);
            #2;
            n++;
        end
        check("drain_ack_seen", ram_ack, 1'b1);
        check("drain_ack_addr", ram_address, 16'h0020);
        @(posedge clk);
        #1;
        check("drain_discard", instr_valid, 1'b0);
        tick();
        check("post_drain_valid", instr_valid, 1'b1);
        check("post_drain_pc", instr_pc, 16'h0000);
        check("post_drain_binary", instruction_binary, rom_word(16'h0000));
        forced_lat = -1;
        repeat (6) tick();

        // PC wrap in ROM.
        redirect(16'hFFFE, 1'b0);
        tick();
        check("wrap_first_pc", instr_pc, 16'hFFFE);
        repeat (8) tick();

        // Random redirects, sources, ready and RAM latency.
        for (int k = 0; k < 12; k++) begin
            redirect(16'($urandom), 1'($urandom_range(0, 1)));
            n = int'($urandom_range(5, 30));
            for (int i = 0; i < n; i++) begin
                instr_ready = 1'($urandom_range(0, 1));
                tick();
            end
        end

        // Async reset with three words buffered and a RAM read in flight.
        instr_ready = 1'b1;
        redirect(16'h0200, 1'b0);
        repeat (8) tick();
        instr_ready = 1'b0;
        forced_lat  = 0;
        redirect(16'h0040, 1'b1);
        repeat (3) tick();
        check("pre_rst_valid", instr_valid, 1'b1);
        check("pre_rst_req", ram_req, 1'b1);
        #2;
        reset = 1'b1;
        #1;
        check("async_rst_valid", instr_valid, 1'b0);
        check("async_rst_req", ram_req, 1'b0);
        check("async_rst_brom", brom_address, RPC);
        check("async_rst_src", execute_from_ram, 1'b0);
        forced_lat  = -1;
        instr_ready = 1'b1;
        restart_model(RPC, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        tick();
        check("rerun_valid", instr_valid, 1'b1);
        check("rerun_pc", instr_pc, RPC);
        repeat (10) tick();
        instr_ready = 1'b0;
        repeat (2) tick();
        check("pops_seen", (n_pops > 60), 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
